// File: rtl/tpu_accum_activation.sv
// tpu_accum_activation: accumulates partial-sum rows per address across tiles, then
// applies ReLU, arithmetic shift and saturation on the last tile and emits the row.
module tpu_accum_activation #(
   parameter int MATRIX_SIZE    = 8,
   parameter int PARTIAL_SUM_BW = 20,
   parameter int DATA_BW        = 8,
   parameter int ACC_BW         = 32,
   parameter int ACC_DEPTH      = 16,
   parameter int ACC_ADDR_BW    = 4
) (
   input  logic                                  clk,
   input  logic                                  rstn,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [PARTIAL_SUM_BW*MATRIX_SIZE-1:0] in_data,
   input  logic [ACC_ADDR_BW-1:0]                in_addr,
   input  logic                                  in_first,
   input  logic                                  in_last,
   input  logic                                  cfg_relu_en,
   input  logic [4:0]                            cfg_shift,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [DATA_BW*MATRIX_SIZE-1:0]        out_data,
   output logic [ACC_ADDR_BW-1:0]                out_addr,
   output logic                                  acc_ovf,
   output logic                                  busy
);
   localparam logic signed [ACC_BW-1:0] SAT_MAX = ACC_BW'((1 << (DATA_BW-1)) - 1);
   localparam logic signed [ACC_BW-1:0] SAT_MIN = ~SAT_MAX;

   logic signed [ACC_BW-1:0] acc_q [ACC_DEPTH][MATRIX_SIZE];
   logic signed [ACC_BW-1:0] sum_d [MATRIX_SIZE];
   logic signed [ACC_BW-1:0] s1_sum_q [MATRIX_SIZE];
   logic [MATRIX_SIZE-1:0] ovf_d;
   logic [ACC_ADDR_BW-1:0] s1_addr_q, out_addr_q;
   logic [DATA_BW*MATRIX_SIZE-1:0] out_data_q, out_data_d;
   logic s1_valid_q, out_valid_q, acc_ovf_q;
   logic s2_take, s1_move, accept;

   assign s2_take   = !out_valid_q || out_ready;
   assign s1_move   = s1_valid_q && s2_take;
   assign in_ready  = !s1_valid_q || s2_take;
   assign accept    = in_valid && in_ready;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_addr  = out_addr_q;
   assign acc_ovf   = acc_ovf_q;
   assign busy      = s1_valid_q || out_valid_q;

   for (genvar i = 0; i < MATRIX_SIZE; i++) begin : g_lane
      logic signed [ACC_BW-1:0] base, add, relu, shr;
      assign base = in_first ? '0 : acc_q[in_addr][i];
      assign add  = {{(ACC_BW-PARTIAL_SUM_BW){in_data[PARTIAL_SUM_BW*i+PARTIAL_SUM_BW-1]}},
                     in_data[PARTIAL_SUM_BW*i +: PARTIAL_SUM_BW]};
      assign sum_d[i] = base + add;
      // Signed overflow: operands agree in sign but the wrapped sum does not.
      assign ovf_d[i] = (base[ACC_BW-1] == add[ACC_BW-1]) && (sum_d[i][ACC_BW-1] != base[ACC_BW-1]);
      assign relu = (cfg_relu_en && s1_sum_q[i][ACC_BW-1]) ? '0 : s1_sum_q[i];
      assign shr  = relu >>> cfg_shift;
      assign out_data_d[DATA_BW*i +: DATA_BW] = (shr > SAT_MAX) ? SAT_MAX[DATA_BW-1:0] :
                                                (shr < SAT_MIN) ? SAT_MIN[DATA_BW-1:0] : shr[DATA_BW-1:0];
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int a = 0; a < ACC_DEPTH; a++)
            for (int l = 0; l < MATRIX_SIZE; l++)
               acc_q[a][l] <= '0;
         for (int l = 0; l < MATRIX_SIZE; l++)
            s1_sum_q[l] <= '0;
         s1_valid_q  <= 1'b0;
         s1_addr_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_addr_q  <= '0;
         acc_ovf_q   <= 1'b0;
      end else begin
         if (accept) begin
            for (int l = 0; l < MATRIX_SIZE; l++)
               acc_q[in_addr][l] <= sum_d[l];
            acc_ovf_q <= acc_ovf_q | (|ovf_d);
         end
         // in_ready guarantees S1 is free or draining whenever a last row is accepted.
         if (accept && in_last) begin
            s1_valid_q <= 1'b1;
            s1_sum_q   <= sum_d;
            s1_addr_q  <= in_addr;
         end else if (s1_move) begin
            s1_valid_q <= 1'b0;
         end
         if (s1_move) begin
            out_valid_q <= 1'b1;
            out_data_q  <= out_data_d;
            out_addr_q  <= s1_addr_q;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_tpu_accum_activation.sv
// tb_tpu_accum_activation: directed vector table plus hand-written backpressure,
// overflow and reset sequences for tpu_accum_activation.
module tb_tpu_accum_activation;
   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [159:0] in_data = '0;
   logic [3:0]   in_addr = '0;
   logic         in_first = 1'b0;
   logic         in_last = 1'b0;
   logic         cfg_relu_en = 1'b0;
   logic [4:0]   cfg_shift = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [63:0]  out_data;
   logic [3:0]   out_addr;
   logic         acc_ovf;
   logic         busy;

   int total = 0;
   int passed = 0;
   logic rec = 1'b0;
   logic [3:0]  got_addr [$];
   logic [63:0] got_data [$];

   typedef struct {
      logic [159:0] data;
      logic [3:0]   addr;
      logic         first;
      logic         last;
      logic         relu;
      logic [4:0]   shift;
      logic [63:0]  exp;
   } vec_t;
   vec_t tv [$];

   tpu_accum_activation dut (
      .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_addr(in_addr), .in_first(in_first), .in_last(in_last),
      .cfg_relu_en(cfg_relu_en), .cfg_shift(cfg_shift), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
      .acc_ovf(acc_ovf), .busy(busy)
   );

   always #5 clk = ~clk;

   always @(negedge clk)
      if (rec && out_valid && out_ready) begin
         got_addr.push_back(out_addr);
         got_data.push_back(out_data);
      end

   function automatic logic [159:0] mk20(input int l0, l1, l2, l3, l4, l5, l6, l7);
      return {l7[19:0], l6[19:0], l5[19:0], l4[19:0], l3[19:0], l2[19:0], l1[19:0], l0[19:0]};
   endfunction

   function automatic logic [63:0] mk8(input int l0, l1, l2, l3, l4, l5, l6, l7);
      return {l7[7:0], l6[7:0], l5[7:0], l4[7:0], l3[7:0], l2[7:0], l1[7:0], l0[7:0]};
   endfunction

   function automatic logic [159:0] rep20(input int v);
      return mk20(v, v, v, v, v, v, v, v);
   endfunction

   function automatic logic [63:0] rep8(input int v);
      return mk8(v, v, v, v, v, v, v, v);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input vec_t v);
      in_valid    = 1'b1;
      in_data     = v.data;
      in_addr     = v.addr;
      in_first    = v.first;
      in_last     = v.last;
      cfg_relu_en = v.relu;
      cfg_shift   = v.shift;
   endtask

   task automatic apply(input string name, input vec_t v);
      drive(v);
      chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
      tick();
      in_valid = 1'b0;
      if (v.last) begin
         chk({name, "_latency"}, 64'(out_valid), 64'd0);
         tick();
         chk({name, "_valid"}, 64'(out_valid), 64'd1);
         chk({name, "_data"}, out_data, v.exp);
         chk({name, "_addr"}, 64'(out_addr), 64'(v.addr));
      end
   endtask

   initial begin
      tv.push_back('{rep20(100), 4'd3, 1'b1, 1'b1, 1'b1, 5'd0, rep8(100)});
      tv.push_back('{rep20(200), 4'd5, 1'b1, 1'b0, 1'b0, 5'd2, 64'd0});
      tv.push_back('{rep20(300), 4'd5, 1'b0, 1'b0, 1'b0, 5'd2, 64'd0});
      tv.push_back('{rep20(-100), 4'd5, 1'b0, 1'b1, 1'b0, 5'd2, rep8(100)});
      tv.push_back('{mk20(-50, 1000, -1000, 127, 128, -129, 0, 5), 4'd6, 1'b1, 1'b1, 1'b0, 5'd0,
                     mk8(-50, 127, -128, 127, 127, -128, 0, 5)});
      tv.push_back('{mk20(-50, 1000, -1000, 127, 128, -129, 0, 5), 4'd6, 1'b1, 1'b1, 1'b1, 5'd0,
                     mk8(0, 127, 0, 127, 127, 0, 0, 5)});
      tv.push_back('{rep20(-7), 4'd8, 1'b1, 1'b1, 1'b0, 5'd1, rep8(-4)});
      tv.push_back('{mk20(524287, -524288, -1, 1, 16, -17, 300, -300), 4'd15, 1'b1, 1'b1, 1'b0, 5'd4,
                     mk8(127, -128, -1, 0, 1, -2, 18, -19)});
      tv.push_back('{rep20(-5), 4'd0, 1'b1, 1'b1, 1'b0, 5'd31, rep8(-1)});

      // Reset state.
      #12;
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_data", out_data, 64'd0);
      chk("rst_out_addr", 64'(out_addr), 64'd0);
      chk("rst_acc_ovf", 64'(acc_ovf), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      rstn = 1'b1;
      tick();
      chk("rst_in_ready", 64'(in_ready), 64'd1);

      foreach (tv[k]) apply($sformatf("vec%0d", k), tv[k]);
      tick();

      // Backpressure: three last rows while the sink stalls.
      out_ready = 1'b0;
      drive('{rep20(10), 4'd0, 1'b1, 1'b1, 1'b0, 5'd0, 64'd0});
      tick();
      chk("bp_ready_after_1", 64'(in_ready), 64'd1);
      drive('{rep20(20), 4'd1, 1'b1, 1'b1, 1'b0, 5'd0, 64'd0});
      tick();
      drive('{rep20(30), 4'd2, 1'b1, 1'b1, 1'b0, 5'd0, 64'd0});
      chk("bp_ready_after_2", 64'(in_ready), 64'd0);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk($sformatf("bp_hold_ready%0d", c), 64'(in_ready), 64'd0);
         chk($sformatf("bp_hold_data%0d", c), out_data, rep8(10));
         chk($sformatf("bp_hold_addr%0d", c), 64'(out_addr), 64'd0);
      end
      rec = 1'b1;
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int c = 0; c < 4; c++) tick();
      rec = 1'b0;
      chk("bp_count", 64'(got_addr.size()), 64'd3);
      for (int c = 0; c < 3; c++)
         if (c < got_addr.size()) begin
            chk($sformatf("bp_order%0d", c), 64'(got_addr[c]), 64'(c));
            chk($sformatf("bp_data%0d", c), got_data[c], rep8(10 * (c + 1)));
         end
      chk("bp_idle", 64'(busy), 64'd0);

      // Overflow: 4096 rows of 0x7FFFF fit, the 4097th wraps past 2^31-1.
      drive('{rep20(524287), 4'd7, 1'b1, 1'b0, 1'b0, 5'd0, 64'd0});
      tick();
      in_first = 1'b0;
      for (int c = 0; c < 4095; c++) tick();
      chk("ovf_before_wrap", 64'(acc_ovf), 64'd0);
      tick();
      chk("ovf_on_wrap", 64'(acc_ovf), 64'd1);
      in_data = rep20(1);
      tick();
      in_valid = 1'b0;
      tick();
      chk("ovf_sticky", 64'(acc_ovf), 64'd1);
      #2 rstn = 1'b0;
      #1 chk("ovf_reset", 64'(acc_ovf), 64'd0);
      #2 rstn = 1'b1;
      tick();
      apply("ovf_row_cleared", '{rep20(5), 4'd7, 1'b0, 1'b1, 1'b0, 5'd0, rep8(5)});
      tick();

      // Reset with both stages full.
      out_ready = 1'b0;
      drive('{rep20(50), 4'd9, 1'b1, 1'b1, 1'b0, 5'd0, 64'd0});
      tick();
      drive('{rep20(60), 4'd10, 1'b1, 1'b1, 1'b0, 5'd0, 64'd0});
      tick();
      in_valid = 1'b0;
      chk("mid_full_valid", 64'(out_valid), 64'd1);
      chk("mid_full_busy", 64'(busy), 64'd1);
      #2 rstn = 1'b0;
      #1 chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      #2 rstn = 1'b1;
      out_ready = 1'b1;
      tick();
      chk("mid_no_stale", 64'(out_valid), 64'd0);
      apply("mid_fresh", '{rep20(-3), 4'd11, 1'b1, 1'b1, 1'b0, 5'd0, rep8(-3)});
      tick();
      chk("mid_single_out", 64'(out_valid), 64'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
